// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller and multi-cycle divide sequencer for the five-stage pipeline
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        if_stallreq,
    input  logic        id_stallreq,
    input  logic        exe_div_start,
    input  logic        mem_stallreq,
    input  logic        exc_flush_req,
    input  logic        stall_cnt_clr,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        div_busy,
    output logic        div_done,
    output logic [5:0]  div_cnt,
    output logic [31:0] stall_cycles
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);
    state_t state, state_nx;
    logic [5:0] cnt_nx;
    logic div_stall;
    logic [4:0] stall_req;
    // divide sequencing: a flush squashes the divide from any state
    always_comb begin
        state_nx = state;
        cnt_nx = div_cnt;
        if (exc_flush_req) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end else begin
            case (state)
                IDLE: if (exe_div_start) begin
                    state_nx = BUSY;
                    cnt_nx = '0;
                end
                BUSY: if (div_cnt == LAST) state_nx = DONE;
                      else cnt_nx = div_cnt + 6'd1;
                DONE: if (!mem_stallreq) begin
                    state_nx = IDLE;
                    cnt_nx = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    // state and iteration index registers
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= IDLE;
            div_cnt <= '0;
        end else begin
            state <= state_nx;
            div_cnt <= cnt_nx;
        end
    end
    // each request holds its own stage and everything upstream; flush wins over all holds
    always_comb begin
        div_stall = (state == IDLE && exe_div_start) || state == BUSY;
        stall_req = {1'b0, mem_stallreq, mem_stallreq | div_stall,
                     mem_stallreq | div_stall | id_stallreq,
                     mem_stallreq | div_stall | id_stallreq | if_stallreq};
        stall = exc_flush_req ? 5'b00000 : stall_req;
        flush = exc_flush_req ? 5'b11110 : 5'b00000;
        div_busy = state == BUSY;
        div_done = state == DONE && !exc_flush_req;
    end
    // saturating count of stalled cycles, clear takes priority
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) stall_cycles <= '0;
        else if (stall_cnt_clr) stall_cycles <= '0;
        else if (stall != 5'b0 && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
    end
endmodule
